// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory responder for the CV32E40P core.
//
// A byte-addressed memory of 2**ADDR_MEM_WIDTH bytes behind an OBI slave port.
// Grants may be delayed by a fixed number of request cycles (GNT_STALL).
// At most two transactions can be outstanding. Responses come back in order,
// exactly RVALID_LAT cycles after their grant.
//
// Ports:
//   clk_i     in   1   clock, rising edge
//   rst_i     in   1   asynchronous active-high reset
//   req_i     in   1   address-phase request
//   gnt_o     out  1   address-phase grant (combinational)
//   addr_i    in  32   byte address, bits [1:0] ignored (word aligned)
//   we_i      in   1   1 = write, 0 = read
//   be_i      in   4   byte enables
//   wdata_i   in  32   write data
//   rvalid_o  out  1   response valid, one cycle per granted transaction
//   rdata_o   out 32   read data, 0 for writes, errors and no-ops
//   err_o     out  1   out-of-range access, qualified by rvalid_o
module cv32e40p_obi_mem_responder #(
  parameter int ADDR_MEM_WIDTH = 13,
  parameter int GNT_STALL      = 0,
  parameter int RVALID_LAT     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int MEM_BYTES = 2 ** ADDR_MEM_WIDTH;
  localparam logic [2:0] STALL_TARGET = 3'(GNT_STALL);

  logic [7:0]  mem_q [MEM_BYTES];
  logic [2:0]  stall_q, stall_d;
  logic [1:0]  outst_q, outst_d;
  // Each stage holds {valid, err, rdata}; the last stage drives the outputs.
  logic [33:0] pipe_q [RVALID_LAT];
  logic [33:0] stage0_d;

  logic [ADDR_MEM_WIDTH-1:0] word_base_s;
  logic [ADDR_MEM_WIDTH-1:0] byte_addr_s [4];
  logic        in_range_s;
  logic        noop_s;
  logic [31:0] rd_word_s;
  logic        addr_lsb_unused_s;

  // The byte offset plays no part in a word-aligned access.
  assign addr_lsb_unused_s = ^addr_i[1:0];

  assign word_base_s = {addr_i[ADDR_MEM_WIDTH-1:2], 2'b00};
  assign in_range_s  = (addr_i[31:ADDR_MEM_WIDTH] == {(32-ADDR_MEM_WIDTH){1'b0}});
  assign noop_s      = (be_i == 4'b0000);

  assign rvalid_o = pipe_q[RVALID_LAT-1][33];
  assign err_o    = pipe_q[RVALID_LAT-1][32];
  assign rdata_o  = pipe_q[RVALID_LAT-1][31:0];

  // Byte addresses of the four lanes of the addressed word and the word read from them.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr_s[k] = word_base_s | ADDR_MEM_WIDTH'(k);
    end
    rd_word_s = {mem_q[byte_addr_s[3]], mem_q[byte_addr_s[2]],
                 mem_q[byte_addr_s[1]], mem_q[byte_addr_s[0]]};
  end

  // Grant: stall count reached and either spare capacity or a slot freed by this cycle's response.
  always_comb begin
    gnt_o = 1'b0;
    if (!rst_i && req_i && (stall_q == STALL_TARGET) &&
        ((outst_q < 2'd2) || rvalid_o)) begin
      gnt_o = 1'b1;
    end else begin
      gnt_o = 1'b0;
    end
  end

  // Stall counter: counts waiting request cycles. It stops at the target so a
  // request blocked only by capacity is granted as soon as a slot frees up.
  always_comb begin
    stall_d = stall_q;
    if (!req_i || gnt_o) begin
      stall_d = 3'd0;
    end else if (stall_q != STALL_TARGET) begin
      stall_d = stall_q + 3'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Outstanding counter: a grant and a response in the same cycle cancel out.
  always_comb begin
    outst_d = outst_q;
    case ({gnt_o, rvalid_o})
      2'b10:   outst_d = outst_q + 2'd1;
      2'b01:   outst_d = outst_q - 2'd1;
      default: outst_d = outst_q;
    endcase
  end

  // Response for the transaction granted this cycle; a read sees memory before any write.
  always_comb begin
    stage0_d = 34'd0;
    if (!gnt_o) begin
      stage0_d = 34'd0;
    end else if (noop_s) begin
      stage0_d = {1'b1, 1'b0, 32'd0};
    end else if (!in_range_s) begin
      stage0_d = {1'b1, 1'b1, 32'd0};
    end else if (!we_i) begin
      stage0_d = {1'b1, 1'b0, rd_word_s};
    end else begin
      stage0_d = {1'b1, 1'b0, 32'd0};
    end
  end

  // Control counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= 3'd0;
      outst_q <= 2'd0;
    end else begin
      stall_q <= stall_d;
      outst_q <= outst_d;
    end
  end

  // Response shift register; reset drops all in-flight responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RVALID_LAT; i++) begin
        pipe_q[i] <= 34'd0;
      end
    end else begin
      pipe_q[0] <= stage0_d;
      for (int i = 1; i < RVALID_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Memory array: byte-enabled in-range writes; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[byte_addr_s[k]] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

endmodule
